bitmanip_shift_pipe: RTL

- Parametrised, pipelined successor to the combinational bitmanip_rol rotator.
- Supports five operations: rotate left, rotate right, logical shift left, logical shift right, arithmetic shift right.
- Operands enter through a valid/ready input port and leave, with an opaque tag, through a valid/ready output port, with full backpressure.
- Sits in the bitmanip execution cluster, between operand issue and writeback arbitration.

---
 rtl/bitmanip_pkg.sv | 19 +
 rtl/bitmanip_shift_level.sv | 22 ++
 rtl/bitmanip_shift_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/bitmanip_pkg.sv
// bitmanip_pkg: shift op encoding and the level-to-stage partition helper
package bitmanip_pkg;
  typedef enum logic [2:0] {ROL = 3'd0, ROR = 3'd1, SLL = 3'd2, SRL = 3'd3, SRA = 3'd4} shift_op_e;
  typedef struct packed {
    int first;
    int last;
  } level_range_t;
  // Levels are dealt out as evenly as possible; earlier stages take the leftovers.
  function automatic level_range_t stage_levels(int stage, int levels, int stages);
    int base;
    int rem;
    level_range_t r;
    base = levels / stages;
    rem = levels % stages;
    r.first = stage * base + (stage < rem ? stage : rem);
    r.last = r.first + base + (stage < rem ? 1 : 0) - 1;
    return r;
  endfunction
endpackage

// File: rtl/bitmanip_shift_level.sv
// bitmanip_shift_level: one log-shifter level moving data by DIST when enabled
module bitmanip_shift_level
  import bitmanip_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  shift_op_e        op,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);
  // Select the moved word for the op; unknown ops pass data through.
  always_comb
    result = !enable ? data :
             op == ROL ? {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]} :
             op == ROR ? {data[DIST-1:0], data[WIDTH-1:DIST]} :
             op == SLL ? {data[WIDTH-DIST-1:0], {DIST{1'b0}}} :
             op == SRL ? {{DIST{1'b0}}, data[WIDTH-1:DIST]} :
             op == SRA ? {{DIST{sign}}, data[WIDTH-1:DIST]} : data;
endmodule

// File: rtl/bitmanip_shift_pipe.sv
// bitmanip_shift_pipe: pipelined rotate/shift unit with valid/ready and tag passthrough
module bitmanip_shift_pipe
  import bitmanip_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  logic [2:0]               op_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         result_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     zero_o
);
  localparam int LEVELS = $clog2(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [LEVELS-1:0] shamt;
    shift_op_e         op;
    logic              sign;
    logic [TAG_W-1:0]  tag;
  } payload_t;
  payload_t stage_in [PIPE_STAGES];
  payload_t stage_d [PIPE_STAGES];
  payload_t stage_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] valid_in;
  logic [PIPE_STAGES-1:0] adv;
  logic legal_op;
  assign legal_op = op_i <= 3'(SRA);
  assign valid_in = PIPE_STAGES'({valid_q, in_valid_i});
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam level_range_t R = stage_levels(s, LEVELS, PIPE_STAGES);
    localparam int F = R.first;
    localparam int L = R.last;
    logic [WIDTH-1:0] chain [F:L+1];
    if (s == 0) begin : g_head
      assign stage_in[s] = '{data: data_i, shamt: legal_op ? shamt_i : '0, op: shift_op_e'(op_i),
                             sign: data_i[WIDTH-1], tag: tag_i};
    end else begin : g_body
      assign stage_in[s] = stage_q[s-1];
    end
    assign chain[F] = stage_in[s].data;
    for (genvar i = F; i <= L; i++) begin : g_lvl
      bitmanip_shift_level #(.WIDTH(WIDTH), .DIST(1 << i)) u_level (
        .data  (chain[i]),
        .enable(stage_in[s].shamt[i]),
        .op    (stage_in[s].op),
        .sign  (stage_in[s].sign),
        .result(chain[i+1])
      );
    end
    assign stage_d[s] = '{data: chain[L+1], shamt: stage_in[s].shamt, op: stage_in[s].op,
                          sign: stage_in[s].sign, tag: stage_in[s].tag};
  end
  // A stage advances when it or any later stage is empty, or the consumer takes the result.
  always_comb begin
    adv = '0;
    for (int k = 0; k < PIPE_STAGES; k++)
      adv[k] = out_ready_i || !(&(valid_q | PIPE_STAGES'((1 << k) - 1)));
  end
  // Stage registers: load on advance, hold while stalled, clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++)
        if (adv[k]) begin
          valid_q[k] <= valid_in[k];
          stage_q[k] <= stage_d[k];
        end
    end
  assign in_ready_o  = adv[0];
  assign out_valid_o = valid_q[PIPE_STAGES-1];
  assign result_o    = stage_q[PIPE_STAGES-1].data;
  assign tag_o       = stage_q[PIPE_STAGES-1].tag;
  assign zero_o      = result_o == '0;
endmodule
